pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall, flush and freeze sequencer for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It sits beside the decode stage and watches three things: decode source registers, EX/MEM destination and control bits, and the decode jump decision. From these it drives the PC, IF/ID and ID/EX pipeline-register enables, the bubble and flush controls, and a sticky halt on illegal decode or a data-memory timeout. It also keeps stall and flush performance counters.

Parameters:
TIMEOUT, 16, max consecutive mem_busy cycles tolerated before halting (legal range 1..255)
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  reset, asynchronous, active-low
id_rs1  in  5  decode rs1 index
id_rs2  in  5  decode rs2 index
id_use_rs1  in  1  decode instruction reads rs1
id_use_rs2  in  1  decode instruction reads rs2
id_is_branch  in  1  decode is BEQ/JALR (operands compared/used in ID)
id_illegal  in  1  decode control word is the all-ones default
id_jump  in  1  control_j from decode (taken branch/jump)
ex_rd  in  5  EX-stage destination
ex_reg_write  in  1  EX RegWrite (ctrl_ex[6])
ex_mem_read  in  1  EX MemRead (ctrl_ex[5])
mem_rd  in  5  MEM-stage destination
mem_mem_read  in  1  MEM MemRead
mem_busy  in  1  data memory not ready this cycle
pc_we  out  1  PC write enable
ifid_we  out  1  IF/ID register write enable
ifid_flush  out  1  load NOP into IF/ID at the next edge
idex_bubble  out  1  load zero control into ID/EX at the next edge
halted  out  1  pipeline halted (sticky)
err_code  out  2  0 none, 1 illegal instruction, 2 memory timeout
stall_cnt  out  CNT_W  cycles with a load-use or branch stall
flush_cnt  out  CNT_W  IF/ID flushes issued

Behaviour:
- States: RUN, FREEZE, HALT (2-bit register).
- Reset (async): state=RUN, halted=0, err_code=0, counters=0, timer=0.
- Outputs after reset are combinational on the current inputs in state RUN.
- Hazard terms (combinational; register 0 never matches):
  - m1 = id_use_rs1 & id_rs1!=0.
  - m2 = id_use_rs2 & id_rs2!=0.
  - ex_hit = (m1 & id_rs1==ex_rd) | (m2 & id_rs2==ex_rd).
  - mem_hit = the same terms against mem_rd.
  - load_use = ex_mem_read & ex_hit.
  - br_haz = id_is_branch & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit)).
  - stall = load_use | br_haz.
- RUN, priority high to low:
  1. id_illegal: pc_we=ifid_we=0, idex_bubble=1; next state HALT, err_code<=1.
  2. mem_busy: pc_we=ifid_we=0, idex_bubble=0 (whole pipe holds); next state FREEZE, timer<=1.
  3. stall: pc_we=ifid_we=0, idex_bubble=1, stall_cnt+1. id_jump is ignored this cycle; the jump is re-evaluated once operands are ready. Worst case is 2 stall cycles (branch after load).
  4. id_jump: pc_we=ifid_we=1, ifid_flush=1, flush_cnt+1.
  5. Otherwise pc_we=ifid_we=1, with ifid_flush=idex_bubble=0.
- FREEZE:
  - All enables 0, ifid_flush=idex_bubble=0.
  - mem_busy=0: next state RUN, timer<=0. The freeze releases on the first not-busy cycle, so the pipe advances on the following cycle.
  - mem_busy=1 with timer==TIMEOUT: next state HALT, err_code<=2.
  - Otherwise timer+1.
  - Decode hazards and id_illegal are ignored in FREEZE; they are re-evaluated in RUN.
- HALT:
  - pc_we=ifid_we=0, idex_bubble=1, halted=1.
  - err_code holds its value; exit only by reset.
- Counters wrap modulo 2^CNT_W. They never increment in FREEZE or HALT.
- ifid_flush and idex_bubble are never both asserted by a stall; a flush implies no stall.
- Reset asserted mid-stall or mid-freeze: immediate return to the reset values, no pending actions kept.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - state encoding localparams: RUN=2'd0, FREEZE=2'd1, HALT=2'd2;
  - err_code values;
  - the opcode constants shared with decode.
- One natural sub-module: hazard_detect, the purely combinational ex_hit/mem_hit/load_use/br_haz logic, instantiated once.
- The FSM, timer and counters stay in the top module.

Test Plan:
1. Load-use: EX ld x5 (ex_mem_read=1, ex_rd=5); ID add x6,x5,x1 (id_use_rs1=1, id_rs1=5) -> exactly one cycle with pc_we=0, ifid_we=0, idex_bubble=1; stall_cnt=1; next cycle pc_we=1.
2. Branch after load: ld x7, then beq x7,x0 (id_is_branch=1). Cycle 1 has EX load -> stall. Cycle 2 has MEM load -> stall. Cycle 3 with id_jump=1 -> ifid_flush=1. Expect stall_cnt=2, flush_cnt=1.
3. x0 filter: ex_rd=0, ex_mem_read=1, id_rs1=0, id_use_rs1=1 -> no stall, pc_we=1.
4. Freeze: mem_busy high 3 cycles -> enables 0 for 4 cycles (RUN detect plus 3 in FREEZE), idex_bubble=0 throughout, return to RUN, no counter change.
5. Timeout with TIMEOUT=4: mem_busy held high -> halted=1, err_code=2 after 6 cycles; remains halted after mem_busy drops; reset_n pulse -> halted=0, err_code=0, counters 0.
6. Illegal decode while id_jump=1: id_illegal=1 -> no flush, idex_bubble=1, next cycle halted=1, err_code=1, pc_we=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: sequencer states, error codes and the opcode
// constants that decode and the hazard sequencer both refer to.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    HALT   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_t;

  localparam int TIMER_W = 8;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 32);

  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic             id_is_branch;
  logic             id_illegal;
  logic             id_jump;
  logic [4:0]       ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;
  logic [4:0]       mem_rd;
  logic             mem_mem_read;
  logic             mem_busy;
  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             halted;
  logic [1:0]       err_code;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_illegal,
           id_jump, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read,
           mem_busy,
    input  pc_we, ifid_we, ifid_flush, idex_bubble, halted, err_code,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_is_branch, id_illegal,
           id_jump, ex_rd, ex_reg_write, ex_mem_read, mem_rd, mem_mem_read,
           mem_busy,
    output pc_we, ifid_we, ifid_flush, idex_bubble, halted, err_code,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational operand hazard check for the instruction sitting in decode.
// Register x0 is hardwired to zero, so it never creates a dependency.
module hazard_detect (
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_id_use_rs1,
  input  logic       i_id_use_rs2,
  input  logic       i_id_is_branch,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_mem_read,
  output logic       o_stall
);

  logic w_m1;
  logic w_m2;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_load_use;
  logic w_br_haz;

  assign w_m1      = i_id_use_rs1 & (i_id_rs1 != 5'd0);
  assign w_m2      = i_id_use_rs2 & (i_id_rs2 != 5'd0);
  assign w_ex_hit  = (w_m1 & (i_id_rs1 == i_ex_rd))  | (w_m2 & (i_id_rs2 == i_ex_rd));
  assign w_mem_hit = (w_m1 & (i_id_rs1 == i_mem_rd)) | (w_m2 & (i_id_rs2 == i_mem_rd));

  // Branches resolve in ID, so they must also wait for ALU results still in EX
  // and for loads still in MEM, which the forwarding paths cannot cover.
  assign w_load_use = i_ex_mem_read & w_ex_hit;
  assign w_br_haz   = i_id_is_branch &
                      ((i_ex_reg_write & w_ex_hit) | (i_mem_mem_read & w_mem_hit));
  assign o_stall    = w_load_use | w_br_haz;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline, with a sticky halt on
// illegal decode or data-memory timeout and stall/flush performance counters.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input logic               clk,
  input logic               reset_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);

  state_t             r_state;
  err_t               r_err;
  logic [TIMER_W-1:0] r_timer;
  logic [CNT_W-1:0]   r_stall_cnt;
  logic [CNT_W-1:0]   r_flush_cnt;

  state_t             w_next_state;
  err_t               w_err_next;
  logic [TIMER_W-1:0] w_timer_next;
  logic               w_stall;
  logic               w_pc_we;
  logic               w_ifid_we;
  logic               w_ifid_flush;
  logic               w_idex_bubble;
  logic               w_stall_inc;
  logic               w_flush_inc;

  hazard_detect u_hazard_detect (
    .i_id_rs1       (bus.id_rs1),
    .i_id_rs2       (bus.id_rs2),
    .i_id_use_rs1   (bus.id_use_rs1),
    .i_id_use_rs2   (bus.id_use_rs2),
    .i_id_is_branch (bus.id_is_branch),
    .i_ex_rd        (bus.ex_rd),
    .i_ex_reg_write (bus.ex_reg_write),
    .i_ex_mem_read  (bus.ex_mem_read),
    .i_mem_rd       (bus.mem_rd),
    .i_mem_mem_read (bus.mem_mem_read),
    .o_stall        (w_stall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= RUN;
      r_err       <= ERR_NONE;
      r_timer     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_err_next;
      r_timer <= w_timer_next;
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  // A memory wait outranks decode hazards: the whole pipe holds without a
  // bubble, and a pending jump is re-evaluated once operands are ready.
  always_comb begin
    w_next_state  = r_state;
    w_err_next    = r_err;
    w_timer_next  = r_timer;
    w_pc_we       = 1'b0;
    w_ifid_we     = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    case (r_state)
      RUN: begin
        if (bus.id_illegal) begin
          w_idex_bubble = 1'b1;
          w_next_state  = HALT;
          w_err_next    = ERR_ILLEGAL;
        end else if (bus.mem_busy) begin
          w_next_state = FREEZE;
          w_timer_next = TIMER_W'(1);
        end else if (w_stall) begin
          w_idex_bubble = 1'b1;
          w_stall_inc   = 1'b1;
        end else if (bus.id_jump) begin
          w_pc_we      = 1'b1;
          w_ifid_we    = 1'b1;
          w_ifid_flush = 1'b1;
          w_flush_inc  = 1'b1;
        end else begin
          w_pc_we   = 1'b1;
          w_ifid_we = 1'b1;
        end
      end
      FREEZE: begin
        if (!bus.mem_busy) begin
          w_next_state = RUN;
          w_timer_next = '0;
        end else if (r_timer == TIMEOUT_V) begin
          w_next_state = HALT;
          w_err_next   = ERR_TIMEOUT;
        end else begin
          w_timer_next = r_timer + TIMER_W'(1);
        end
      end
      HALT: begin
        w_idex_bubble = 1'b1;
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  assign bus.pc_we       = w_pc_we;
  assign bus.ifid_we     = w_ifid_we;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_bubble = w_idex_bubble;
  assign bus.halted      = (r_state == HALT);
  assign bus.err_code    = r_err;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: each step queues its expected outputs,
// which are popped and compared on the falling edge of that cycle.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic        pc_we;
    logic        ifid_we;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        halted;
    logic [1:0]  err_code;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  exp_t  expQ[$];
  string tagQ[$];

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired obs=running exp=finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t mk(input logic pc, input logic ifid, input logic fl,
                              input logic bub, input logic hlt, input logic [1:0] err,
                              input int sc, input int fc);
    exp_t e;
    e.pc_we       = pc;
    e.ifid_we     = ifid;
    e.ifid_flush  = fl;
    e.idex_bubble = bub;
    e.halted      = hlt;
    e.err_code    = err;
    e.stall_cnt   = 32'(sc);
    e.flush_cnt   = 32'(fc);
    return e;
  endfunction

  task automatic clearInputs();
    bus.id_rs1       = 5'd0;
    bus.id_rs2       = 5'd0;
    bus.id_use_rs1   = 1'b0;
    bus.id_use_rs2   = 1'b0;
    bus.id_is_branch = 1'b0;
    bus.id_illegal   = 1'b0;
    bus.id_jump      = 1'b0;
    bus.ex_rd        = 5'd0;
    bus.ex_reg_write = 1'b0;
    bus.ex_mem_read  = 1'b0;
    bus.mem_rd       = 5'd0;
    bus.mem_mem_read = 1'b0;
    bus.mem_busy     = 1'b0;
  endtask

  task automatic cmp(input string tag, input string field,
                     input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    e = expQ.pop_front();
    t = tagQ.pop_front();
    cmp(t, "pc_we",       32'(bus.pc_we),       32'(e.pc_we));
    cmp(t, "ifid_we",     32'(bus.ifid_we),     32'(e.ifid_we));
    cmp(t, "ifid_flush",  32'(bus.ifid_flush),  32'(e.ifid_flush));
    cmp(t, "idex_bubble", 32'(bus.idex_bubble), 32'(e.idex_bubble));
    cmp(t, "halted",      32'(bus.halted),      32'(e.halted));
    cmp(t, "err_code",    32'(bus.err_code),    32'(e.err_code));
    cmp(t, "stall_cnt",   bus.stall_cnt,        e.stall_cnt);
    cmp(t, "flush_cnt",   bus.flush_cnt,        e.flush_cnt);
  endtask

  // Inputs are already driven; queue the expectation, check mid-cycle, then
  // advance past the next rising edge.
  task automatic applyStimulus(input exp_t e, input string tag);
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset_n = 1'b0;
    clearInputs();
    applyStimulus(mk(1,1,0,0,0,0,0,0), "reset");
    reset_n = 1'b1;

    // Load-use on rs1
    bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd5;
    applyStimulus(mk(0,0,0,1,0,0,0,0), "lu_stall");
    clearInputs();
    bus.mem_mem_read = 1; bus.mem_rd = 5'd5; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd5;
    applyStimulus(mk(1,1,0,0,0,0,1,0), "lu_release");

    // Branch after load: two stall cycles, then the jump flushes
    clearInputs();
    bus.ex_mem_read = 1; bus.ex_reg_write = 1; bus.ex_rd = 5'd7;
    bus.id_is_branch = 1; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd7;
    bus.id_use_rs2 = 1; bus.id_rs2 = 5'd0; bus.id_jump = 1;
    applyStimulus(mk(0,0,0,1,0,0,1,0), "br_ld_ex");
    bus.ex_mem_read = 0; bus.ex_reg_write = 0; bus.ex_rd = 5'd0;
    bus.mem_mem_read = 1; bus.mem_rd = 5'd7;
    applyStimulus(mk(0,0,0,1,0,0,2,0), "br_ld_mem");
    bus.mem_mem_read = 0; bus.mem_rd = 5'd0;
    applyStimulus(mk(1,1,1,0,0,0,3,0), "br_jump");
    clearInputs();
    applyStimulus(mk(1,1,0,0,0,0,3,1), "br_after");

    // ALU result in EX feeding a branch stalls; feeding a plain op does not
    bus.ex_reg_write = 1; bus.ex_rd = 5'd9; bus.id_is_branch = 1;
    bus.id_use_rs2 = 1; bus.id_rs2 = 5'd9;
    applyStimulus(mk(0,0,0,1,0,0,3,1), "br_alu");
    bus.id_is_branch = 0;
    applyStimulus(mk(1,1,0,0,0,0,4,1), "alu_fwd");

    // x0 never matches; an unused operand never matches
    clearInputs();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd0; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd0;
    applyStimulus(mk(1,1,0,0,0,0,4,1), "x0_filter");
    bus.ex_rd = 5'd3; bus.id_use_rs1 = 0; bus.id_rs1 = 5'd3;
    applyStimulus(mk(1,1,0,0,0,0,4,1), "unused_rs1");

    // Freeze with a load-use hazard and jump pending: no bubble, no counting
    clearInputs();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_use_rs1 = 1; bus.id_rs1 = 5'd5;
    bus.id_jump = 1; bus.mem_busy = 1;
    applyStimulus(mk(0,0,0,0,0,0,4,1), "frz_detect");
    applyStimulus(mk(0,0,0,0,0,0,4,1), "frz_1");
    applyStimulus(mk(0,0,0,0,0,0,4,1), "frz_2");
    bus.mem_busy = 0;
    applyStimulus(mk(0,0,0,0,0,0,4,1), "frz_release");
    clearInputs();
    applyStimulus(mk(1,1,0,0,0,0,4,1), "frz_run");

    // Timeout: RUN detect, FREEZE with timer 1..4, then HALT
    bus.mem_busy = 1;
    for (int i = 0; i < 5; i++) applyStimulus(mk(0,0,0,0,0,0,4,1), "to_wait");
    applyStimulus(mk(0,0,0,1,1,2,4,1), "to_halt");
    bus.mem_busy = 0; bus.id_jump = 1;
    applyStimulus(mk(0,0,0,1,1,2,4,1), "to_sticky");
    clearInputs();
    reset_n = 1'b0;
    applyStimulus(mk(1,1,0,0,0,0,0,0), "to_reset");
    reset_n = 1'b1;

    // Illegal decode outranks a jump and halts with code 1
    bus.id_illegal = 1; bus.id_jump = 1;
    applyStimulus(mk(0,0,0,1,0,0,0,0), "ill_detect");
    clearInputs();
    applyStimulus(mk(0,0,0,1,1,1,0,0), "ill_halt");

    // Reset asserted in the middle of a freeze drops everything
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    bus.mem_busy = 1;
    applyStimulus(mk(0,0,0,0,0,0,0,0), "mid_frz_enter");
    reset_n = 1'b0;
    bus.mem_busy = 0;
    applyStimulus(mk(1,1,0,0,0,0,0,0), "mid_frz_reset");
    reset_n = 1'b1;
    applyStimulus(mk(1,1,0,0,0,0,0,0), "post_reset");

    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_drain observed=%0d expected=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
